capture_uploader: RTL

Capture buffer and upload engine for the logic analyzer: stores sampled data in a circular RAM while armed, keeps capturing a programmed number of post-trigger samples once `run` fires, then streams the stored samples to the UART transmitter, most recent first, one byte per sample. Sits between the sampler/trigger path and the UART transmit mux, on the data side of `data_meta_mux`.

---
 rtl/acsp_pkg.sv | 21 ++
 rtl/capture_uploader_if.sv | 12 +
 rtl/capture_ram.sv | 23 ++
 rtl/capture_uploader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/acsp_pkg.sv
// Shared types for the capture/upload path: FSM state encoding, default RAM
// address width and the 16-bit count type.
package acsp_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 12;

  typedef logic [15:0] count_t;

  typedef enum logic [3:0] {
    IDLE,
    CAPTURE,
    DELAY,
    UPLOAD_SETUP,
    FETCH,
    SEND,
    WAIT_HI,
    WAIT_LO,
    DONE
  } uploader_state_t;

endpackage

// File: rtl/capture_uploader_if.sv
// Byte handshake between the upload engine (master) and the UART transmitter
// (slave): one-cycle send strobe with data, busy returned by the UART.
interface capture_uploader_if #(
  parameter int SAMPLE_WIDTH = 8
);
  logic                    trans_en;
  logic [SAMPLE_WIDTH-1:0] tran_data;
  logic                    tx_busy;

  modport master (output trans_en, output tran_data, input tx_busy);
  modport slave  (input trans_en, input tran_data, output tx_busy);
endinterface

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered output that holds until the next read enable.
module capture_ram #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = 12
) (
  input  logic                    clock,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [SAMPLE_WIDTH-1:0] rd_data
);

  logic [SAMPLE_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/capture_uploader.sv
// Circular capture buffer with post-trigger delay, then newest-first upload to
// the UART. Define UPLOAD_CHECKSUM_EN to append an XOR checksum byte.
module capture_uploader
  import acsp_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    arm,
  input  logic                    run,
  input  logic                    load_counts,
  input  count_t                  read_count,
  input  count_t                  delay_count,
  capture_uploader_if.master      uart,
  output logic                    upload_busy,
  output logic                    upload_done
);

  // state        | meaning
  // IDLE         | waiting for arm rising edge
  // CAPTURE      | writing samples, watching run
  // DELAY        | writing post-trigger samples until delay count reached
  // UPLOAD_SETUP | point at newest sample, size the upload
  // FETCH        | RAM read issued
  // SEND         | strobe byte once UART is idle
  // WAIT_HI      | wait for UART to go busy
  // WAIT_LO      | wait for UART to finish
  // DONE         | one-cycle completion pulse

  localparam int DEPTH       = 2**ADDR_WIDTH;
  localparam int DEPTH_CAP_I = (DEPTH > 65535) ? 65535 : DEPTH;
  localparam count_t DEPTH_CAP = count_t'(DEPTH_CAP_I);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  uploader_state_t state, state_nxt;
  logic                    arm_q, arm_edge;
  logic [ADDR_WIDTH-1:0]   wr_ptr, rd_ptr;
  logic                    filled;
  count_t                  read_cfg, delay_cfg, read_act, delay_act;
  count_t                  delay_left, remaining, upload_len;
  logic                    wr_en, rd_en, send, csum_phase;
  logic [SAMPLE_WIDTH-1:0] rd_data, tx_byte;

  capture_ram #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (sample_in),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  assign arm_edge = arm && !arm_q;

  // An unwrapped buffer only holds wr_ptr samples, so never read past them.
  always_comb begin
    upload_len = (read_act > DEPTH_CAP) ? DEPTH_CAP : read_act;
    if (!filled && upload_len > count_t'(wr_ptr)) upload_len = count_t'(wr_ptr);
  end

`ifdef UPLOAD_CHECKSUM_EN
  logic [SAMPLE_WIDTH-1:0] csum;

  always_ff @(posedge clock) begin
    if (reset) begin
      csum       <= '0;
      csum_phase <= 1'b0;
    end else begin
      if (state == UPLOAD_SETUP) begin
        csum       <= '0;
        csum_phase <= (upload_len == '0);
      end else if (state == WAIT_LO && !uart.tx_busy && remaining == '0) begin
        csum_phase <= 1'b1;
      end
      if (send && !csum_phase) csum <= csum ^ rd_data;
    end
  end

  assign tx_byte = csum_phase ? csum : rd_data;
`else
  assign csum_phase = 1'b0;
  assign tx_byte    = rd_data;
`endif

  always_comb begin
    state_nxt   = state;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    send        = 1'b0;
    upload_done = 1'b0;
    upload_busy = (state != IDLE) && (state != DONE);
    case (state)
      IDLE:    if (arm_edge) state_nxt = CAPTURE;
      CAPTURE: begin
        wr_en = sample_valid;
        if (run) state_nxt = (delay_act == '0) ? UPLOAD_SETUP : DELAY;
      end
      DELAY: begin
        wr_en = sample_valid;
        if (sample_valid && delay_left == 16'd1) state_nxt = UPLOAD_SETUP;
      end
      UPLOAD_SETUP: begin
`ifdef UPLOAD_CHECKSUM_EN
        state_nxt = (upload_len == '0) ? SEND : FETCH;
`else
        state_nxt = (upload_len == '0) ? DONE : FETCH;
`endif
      end
      FETCH: begin
        rd_en     = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (!uart.tx_busy) begin
        send      = 1'b1;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: if (uart.tx_busy) state_nxt = WAIT_LO;
      WAIT_LO: if (!uart.tx_busy) begin
        if (remaining != '0) state_nxt = FETCH;
`ifdef UPLOAD_CHECKSUM_EN
        else if (!csum_phase) state_nxt = SEND;
`endif
        else state_nxt = DONE;
      end
      DONE: begin
        upload_done = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign uart.trans_en  = send;
  assign uart.tran_data = send ? tx_byte : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      arm_q      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      filled     <= 1'b0;
      read_cfg   <= '0;
      delay_cfg  <= '0;
      read_act   <= '0;
      delay_act  <= '0;
      delay_left <= '0;
      remaining  <= '0;
    end else begin
      state <= state_nxt;
      arm_q <= arm;
      if (load_counts) begin
        read_cfg  <= read_count;
        delay_cfg <= delay_count;
      end
      // Counts are snapshotted at arm so a mid-capture reload waits a run.
      if (state == IDLE && arm_edge) begin
        wr_ptr    <= '0;
        filled    <= 1'b0;
        read_act  <= read_cfg;
        delay_act <= delay_cfg;
      end
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        if (wr_ptr == PTR_MAX) filled <= 1'b1;
      end
      if (state == CAPTURE && run) delay_left <= delay_act;
      if (state == DELAY && sample_valid) delay_left <= delay_left - 16'd1;
      if (state == UPLOAD_SETUP) begin
        rd_ptr    <= wr_ptr - PTR_ONE;
        remaining <= upload_len;
      end
      if (send && !csum_phase) begin
        rd_ptr    <= rd_ptr - PTR_ONE;
        remaining <= remaining - 16'd1;
      end
    end
  end

endmodule
